// File: rtl/chacha_pkg.sv
// Shared constants, state layout and index tables for the ChaCha20 block core.
package chacha_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned NUM_WORDS = 16;
   localparam int unsigned STATE_W   = WORD_W * NUM_WORDS;
   localparam int unsigned KEY_W     = 256;
   localparam int unsigned NONCE_W   = 96;

   localparam logic [WORD_W-1:0] SIGMA0 = 32'h6170_7865;
   localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320_646e;
   localparam logic [WORD_W-1:0] SIGMA2 = 32'h7962_2d32;
   localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b20_6574;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ROUND = 2'd1;
   localparam logic [1:0] ST_FINAL = 2'd2;
   localparam logic [1:0] ST_OUT   = 2'd3;

   typedef logic [NUM_WORDS-1:0][WORD_W-1:0] state_t;

   // Entry [lane*4 + pos] gives the state word feeding quarter-round lane, pos 0..3 = a..d
   localparam logic [3:0] COL_IDX [16] = '{
      4'd0, 4'd4, 4'd8,  4'd12,
      4'd1, 4'd5, 4'd9,  4'd13,
      4'd2, 4'd6, 4'd10, 4'd14,
      4'd3, 4'd7, 4'd11, 4'd15
   };

   localparam logic [3:0] DIAG_IDX [16] = '{
      4'd0, 4'd5, 4'd10, 4'd15,
      4'd1, 4'd6, 4'd11, 4'd12,
      4'd2, 4'd7, 4'd8,  4'd13,
      4'd3, 4'd4, 4'd9,  4'd14
   };

   function automatic state_t init_state(input logic [KEY_W-1:0]   key,
                                         input logic [NONCE_W-1:0] nonce,
                                         input logic [WORD_W-1:0]  counter);
      state_t s;
      s[0]  = SIGMA0;
      s[1]  = SIGMA1;
      s[2]  = SIGMA2;
      s[3]  = SIGMA3;
      for (int i = 0; i < 8; i++) s[4+i] = key[32*i +: 32];
      s[12] = counter;
      for (int j = 0; j < 3; j++) s[13+j] = nonce[32*j +: 32];
      return s;
   endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter round on four 32-bit words.
module chacha_qr (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [31:0] c_i,
   input  logic [31:0] d_i,
   output logic [31:0] a_o,
   output logic [31:0] b_o,
   output logic [31:0] c_o,
   output logic [31:0] d_o
);

   logic [31:0] a1, b1, c1, d1, a2, b2, c2, d2;
   logic [31:0] b1x, d1x, b2x, d2x;

   assign a1  = a_i + b_i;
   assign d1x = d_i ^ a1;
   assign d1  = {d1x[15:0], d1x[31:16]};
   assign c1  = c_i + d1;
   assign b1x = b_i ^ c1;
   assign b1  = {b1x[19:0], b1x[31:20]};
   assign a2  = a1 + b1;
   assign d2x = d1 ^ a2;
   assign d2  = {d2x[23:0], d2x[31:24]};
   assign c2  = c1 + d2;
   assign b2x = b1 ^ c2;
   assign b2  = {b2x[24:0], b2x[31:25]};

   assign a_o = a2;
   assign b_o = b2;
   assign c_o = c2;
   assign d_o = d2;

endmodule

// File: rtl/chacha_round_sel.sv
// Gathers state words into the four quarter-round lanes and scatters results back,
// selecting column or diagonal wiring.
module chacha_round_sel
   import chacha_pkg::*;
(
   input  logic                diag,
   input  logic [STATE_W-1:0]  state_in,
   input  logic [STATE_W-1:0]  qr_out,
   output logic [STATE_W-1:0]  qr_in,
   output logic [STATE_W-1:0]  state_out
);

   state_t                     st_in, st_out;
   logic [3:0][3:0][WORD_W-1:0] qin, qout;
   logic [3:0]                 idx;

   assign st_in     = state_in;
   assign qout      = qr_out;
   assign qr_in     = qin;
   assign state_out = st_out;

   always_comb begin
      st_out = st_in;
      qin    = '0;
      idx    = '0;
      for (int l = 0; l < 4; l++) begin
         for (int p = 0; p < 4; p++) begin
            idx = diag ? DIAG_IDX[4'(l*4+p)] : COL_IDX[4'(l*4+p)];
            qin[2'(l)][2'(p)] = st_in[idx];
            st_out[idx]       = qout[2'(l)][2'(p)];
         end
      end
   end

endmodule

// File: rtl/chacha_block_core.sv
// Sequential ChaCha block function: one half-round per cycle, feed-forward, then
// a held 512-bit keystream under valid/ready.
module chacha_block_core
   import chacha_pkg::*;
#(
   parameter int unsigned ROUNDS = 20
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [255:0]   key,
   input  logic [95:0]    nonce,
   input  logic [31:0]    counter,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [511:0]   keystream,
   output logic           busy
);

   localparam int unsigned RND_W = $clog2(ROUNDS + 1);

   logic [1:0]       fsm_q, fsm_d;
   logic [RND_W-1:0] rnd_q, rnd_d;
   state_t           st_q, st_d;
   state_t           init_q, init_d;
   state_t           ks_q, ks_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;

   logic [STATE_W-1:0]          round_next;
   logic [3:0][3:0][WORD_W-1:0] qr_in, qr_out;

   chacha_round_sel u_round_sel (
      .diag      (rnd_q[0]),
      .state_in  (st_q),
      .qr_out    (qr_out),
      .qr_in     (qr_in),
      .state_out (round_next)
   );

   for (genvar l = 0; l < 4; l++) begin : g_qr
      chacha_qr u_qr (
         .a_i (qr_in[l][0]),
         .b_i (qr_in[l][1]),
         .c_i (qr_in[l][2]),
         .d_i (qr_in[l][3]),
         .a_o (qr_out[l][0]),
         .b_o (qr_out[l][1]),
         .c_o (qr_out[l][2]),
         .d_o (qr_out[l][3])
      );
   end

   always_comb begin
      fsm_d       = fsm_q;
      rnd_d       = rnd_q;
      st_d        = st_q;
      init_d      = init_q;
      ks_d        = ks_q;
      out_valid_d = out_valid_q;
      case (fsm_q)
         ST_IDLE: begin
            if (in_valid) begin
               st_d   = init_state(key, nonce, counter);
               init_d = init_state(key, nonce, counter);
               rnd_d  = '0;
               fsm_d  = ST_ROUND;
            end
         end
         ST_ROUND: begin
            st_d  = round_next;
            rnd_d = rnd_q + 1'b1;
            if (rnd_q == RND_W'(ROUNDS - 1)) fsm_d = ST_FINAL;
         end
         ST_FINAL: begin
            // Per-word modular add; no carry crosses word boundaries
            for (int i = 0; i < 16; i++) ks_d[4'(i)] = st_q[4'(i)] + init_q[4'(i)];
            out_valid_d = 1'b1;
            fsm_d       = ST_OUT;
         end
         default: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               fsm_d       = ST_IDLE;
            end
         end
      endcase
      in_ready_d = (fsm_d == ST_IDLE);
      busy_d     = (fsm_d == ST_ROUND) || (fsm_d == ST_FINAL);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsm_q       <= ST_IDLE;
         rnd_q       <= '0;
         st_q        <= '0;
         init_q      <= '0;
         ks_q        <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         rnd_q       <= rnd_d;
         st_q        <= st_d;
         init_q      <= init_d;
         ks_q        <= ks_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign keystream = ks_q;

endmodule
